// File: rtl/bp_addr_gen_bank.sv
// bp_addr_gen_bank
// Address-generation bank for the LSTM backpropagation-through-time engine.
// Three sequencers share one clock and reset:
//   - delta sequencer : activation read address and delta-gate write address,
//                       one slot of DELTA_TIME enabled cycles per cell
//   - dstate sequencer: cell-state-delta read address and its write address,
//                       the latter delayed DSTATE_DELAY clocks
//   - dwu sequencer   : delta-gate and weight read addresses for the
//                       delta x weight accumulation, with DWU_DELAY idle
//                       cycles after every NUM_CELL run
// Ports:
//   clk              rising-edge clock
//   rst              synchronous active-high reset, priority over enables
//   en_delta         advances the delta and dstate sequencers
//   en_dwu           advances the dwu sequencer
//   o_addr_aioht     a/i/o/h/target read address   (t*NUM_CELL+n)
//   o_addr_dgates    delta-gate write address (previous slot's aioht)
//   o_addr_dstate_rd dstate read address           (n)
//   o_addr_dstate_wr dstate write address (rd delayed DSTATE_DELAY clocks)
//   o_addr_d         delta-gate read address       (t*NUM_CELL+i)
//   o_addr_w         weight read address           (i*NUM_INPUT+j)
// DSTATE_DELAY must be at least 1.

module bp_addr_gen_bank #(
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned NUM_CELL     = 8,
  parameter int unsigned NUM_INPUT    = 53,
  parameter int unsigned TIMESTEP     = 7,
  parameter int unsigned DELTA_TIME   = 12,
  parameter int unsigned DSTATE_DELAY = 12,
  parameter int unsigned DWU_DELAY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_delta,
  input  logic                  en_dwu,
  output logic [ADDR_WIDTH-1:0] o_addr_aioht,
  output logic [ADDR_WIDTH-1:0] o_addr_dgates,
  output logic [ADDR_WIDTH-1:0] o_addr_dstate_rd,
  output logic [ADDR_WIDTH-1:0] o_addr_dstate_wr,
  output logic [ADDR_WIDTH-1:0] o_addr_d,
  output logic [ADDR_WIDTH-1:0] o_addr_w
);

  localparam int unsigned PH_W     = (DELTA_TIME > 1) ? $clog2(DELTA_TIME) : 1;
  localparam int unsigned N_W      = (NUM_CELL > 1)   ? $clog2(NUM_CELL)   : 1;
  localparam int unsigned T_W      = (TIMESTEP > 1)   ? $clog2(TIMESTEP)   : 1;
  localparam int unsigned J_W      = (NUM_INPUT > 1)  ? $clog2(NUM_INPUT)  : 1;
  localparam int unsigned G_W      = (DWU_DELAY > 1)  ? $clog2(DWU_DELAY)  : 1;
  localparam int unsigned GAP_LAST = (DWU_DELAY > 0)  ? DWU_DELAY - 1      : 0;

  localparam logic [ADDR_WIDTH-1:0] ADDR_T0 = ADDR_WIDTH'((TIMESTEP - 1) * NUM_CELL);

  // ---------------------------------------------------------------------------
  // Delta / dstate-read sequencer
  // ---------------------------------------------------------------------------
  logic [PH_W-1:0]       ph_q, ph_nxt;
  logic [T_W-1:0]        t_q, t_nxt;
  logic [N_W-1:0]        n_q, n_nxt;
  logic [ADDR_WIDTH-1:0] aioht_nxt, dgates_nxt, dstate_rd_nxt;

  // Slot advance happens on the last phase of a slot; dgates captures the
  // address of the slot that just finished.
  always_comb begin
    ph_nxt     = ph_q;
    t_nxt      = t_q;
    n_nxt      = n_q;
    dgates_nxt = o_addr_dgates;
    if (en_delta) begin
      if (ph_q == PH_W'(DELTA_TIME - 1)) begin
        ph_nxt     = '0;
        dgates_nxt = o_addr_aioht;
        if (n_q == N_W'(NUM_CELL - 1)) begin
          n_nxt = '0;
          t_nxt = (t_q == '0) ? T_W'(TIMESTEP - 1) : t_q - T_W'(1);
        end else begin
          n_nxt = n_q + N_W'(1);
        end
      end else begin
        ph_nxt = ph_q + PH_W'(1);
      end
    end
    aioht_nxt     = ADDR_WIDTH'(t_nxt) * ADDR_WIDTH'(NUM_CELL) + ADDR_WIDTH'(n_nxt);
    dstate_rd_nxt = ADDR_WIDTH'(n_nxt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ph_q             <= '0;
      t_q              <= T_W'(TIMESTEP - 1);
      n_q              <= '0;
      o_addr_aioht     <= ADDR_T0;
      o_addr_dgates    <= ADDR_T0;
      o_addr_dstate_rd <= '0;
    end else begin
      ph_q             <= ph_nxt;
      t_q              <= t_nxt;
      n_q              <= n_nxt;
      o_addr_aioht     <= aioht_nxt;
      o_addr_dgates    <= dgates_nxt;
      o_addr_dstate_rd <= dstate_rd_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Dstate write delay line: free-running, independent of en_delta
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] dstate_dly_q [DSTATE_DELAY];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(DSTATE_DELAY); k++) begin
        dstate_dly_q[k] <= '0;
      end
    end else begin
      dstate_dly_q[0] <= o_addr_dstate_rd;
      for (int k = 1; k < int'(DSTATE_DELAY); k++) begin
        dstate_dly_q[k] <= dstate_dly_q[k-1];
      end
    end
  end

  assign o_addr_dstate_wr = dstate_dly_q[DSTATE_DELAY-1];

  // ---------------------------------------------------------------------------
  // Dwu accumulation sequencer
  // ---------------------------------------------------------------------------
  typedef enum logic {
    DWU_RUN,
    DWU_GAP
  } dwu_state_t;

  dwu_state_t            dwu_state_q, dwu_state_nxt;
  logic [T_W-1:0]        tw_q, tw_nxt;
  logic [J_W-1:0]        j_q, j_nxt;
  logic [N_W-1:0]        i_q, i_nxt;
  logic [G_W-1:0]        g_q, g_nxt;
  logic                  row_done;
  logic [ADDR_WIDTH-1:0] d_nxt, w_nxt;

  // Run walks i across the cells; the gap holds outputs; row_done starts the
  // next input column (and timestep when the columns wrap).
  always_comb begin
    dwu_state_nxt = dwu_state_q;
    tw_nxt        = tw_q;
    j_nxt         = j_q;
    i_nxt         = i_q;
    g_nxt         = g_q;
    row_done      = 1'b0;
    if (en_dwu) begin
      case (dwu_state_q)
        DWU_RUN: begin
          if (i_q == N_W'(NUM_CELL - 1)) begin
            if (DWU_DELAY == 0) begin
              row_done = 1'b1;
            end else begin
              dwu_state_nxt = DWU_GAP;
              g_nxt         = '0;
            end
          end else begin
            i_nxt = i_q + N_W'(1);
          end
        end
        DWU_GAP: begin
          if (g_q == G_W'(GAP_LAST)) begin
            dwu_state_nxt = DWU_RUN;
            row_done      = 1'b1;
          end else begin
            g_nxt = g_q + G_W'(1);
          end
        end
        default: dwu_state_nxt = DWU_RUN;
      endcase
      if (row_done) begin
        i_nxt = '0;
        if (j_q == J_W'(NUM_INPUT - 1)) begin
          j_nxt  = '0;
          tw_nxt = (tw_q == '0) ? T_W'(TIMESTEP - 1) : tw_q - T_W'(1);
        end else begin
          j_nxt = j_q + J_W'(1);
        end
      end
    end
    d_nxt = ADDR_WIDTH'(tw_nxt) * ADDR_WIDTH'(NUM_CELL) + ADDR_WIDTH'(i_nxt);
    w_nxt = ADDR_WIDTH'(i_nxt) * ADDR_WIDTH'(NUM_INPUT) + ADDR_WIDTH'(j_nxt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dwu_state_q <= DWU_RUN;
      tw_q        <= T_W'(TIMESTEP - 1);
      j_q         <= '0;
      i_q         <= '0;
      g_q         <= '0;
      o_addr_d    <= ADDR_T0;
      o_addr_w    <= '0;
    end else begin
      dwu_state_q <= dwu_state_nxt;
      tw_q        <= tw_nxt;
      j_q         <= j_nxt;
      i_q         <= i_nxt;
      g_q         <= g_nxt;
      o_addr_d    <= d_nxt;
      o_addr_w    <= w_nxt;
    end
  end

endmodule

// File: tb/tb_bp_addr_gen_bank.sv
// Directed bench for bp_addr_gen_bank: default-parameter instance plus a
// NUM_CELL=53 / DWU_DELAY=3 instance for the row-period case.

module tb_bp_addr_gen_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_delta, en_dwu, en_dwu_b;
  logic [11:0] aioht, dgates, ds_rd, ds_wr, d, w;
  logic [11:0] b_aioht, b_dgates, b_ds_rd, b_ds_wr, b_d, b_w;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bp_addr_gen_bank dut (
    .clk              (clk),
    .rst              (rst),
    .en_delta         (en_delta),
    .en_dwu           (en_dwu),
    .o_addr_aioht     (aioht),
    .o_addr_dgates    (dgates),
    .o_addr_dstate_rd (ds_rd),
    .o_addr_dstate_wr (ds_wr),
    .o_addr_d         (d),
    .o_addr_w         (w)
  );

  bp_addr_gen_bank #(
    .NUM_CELL  (53),
    .DWU_DELAY (3)
  ) dut_b (
    .clk              (clk),
    .rst              (rst),
    .en_delta         (1'b0),
    .en_dwu           (en_dwu_b),
    .o_addr_aioht     (b_aioht),
    .o_addr_dgates    (b_dgates),
    .o_addr_dstate_rd (b_ds_rd),
    .o_addr_dstate_wr (b_ds_wr),
    .o_addr_d         (b_d),
    .o_addr_w         (b_w)
  );

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; en_delta = 1'b0; en_dwu = 1'b0; en_dwu_b = 1'b0;
    step(2);
    chk("rst_aioht", aioht, 12'd48);
    chk("rst_dgates", dgates, 12'd48);
    chk("rst_ds_rd", ds_rd, 12'd0);
    chk("rst_ds_wr", ds_wr, 12'd0);
    chk("rst_d", d, 12'd48);
    chk("rst_w", w, 12'd0);
    chk("b_rst_aioht", b_aioht, 12'd318);
    chk("b_rst_dgates", b_dgates, 12'd318);
    chk("b_rst_ds", b_ds_rd | b_ds_wr, 12'd0);
    chk("b_rst_d", b_d, 12'd318);
    chk("b_rst_w", b_w, 12'd0);

    // Delta / dstate sequencing
    rst = 1'b0; en_delta = 1'b1;
    step(11);
    chk("dl11_aioht", aioht, 12'd48);
    chk("dl11_dgates", dgates, 12'd48);
    chk("dl11_ds_rd", ds_rd, 12'd0);
    step(1);
    chk("dl12_aioht", aioht, 12'd49);
    chk("dl12_dgates", dgates, 12'd48);
    chk("dl12_ds_rd", ds_rd, 12'd1);
    chk("dl12_ds_wr", ds_wr, 12'd0);
    step(11);
    chk("dl23_ds_wr", ds_wr, 12'd0);
    step(1);
    chk("dl24_ds_wr", ds_wr, 12'd1);
    chk("dl24_ds_rd", ds_rd, 12'd2);
    step(71);
    chk("dl95_aioht", aioht, 12'd55);
    chk("dl95_ds_rd", ds_rd, 12'd7);
    step(1);
    chk("dl96_aioht", aioht, 12'd40);
    chk("dl96_dgates", dgates, 12'd55);
    chk("dl96_ds_rd", ds_rd, 12'd0);
    chk("dl96_d_idle", d, 12'd48);
    chk("dl96_w_idle", w, 12'd0);

    // Dwu sequencing, delta frozen
    en_delta = 1'b0; en_dwu = 1'b1;
    step(7);
    chk("dw7_d", d, 12'd55);
    chk("dw7_w", w, 12'd371);
    chk("dw7_aioht_frz", aioht, 12'd40);
    step(2);
    chk("dw9_d_hold", d, 12'd55);
    chk("dw9_w_hold", w, 12'd371);
    step(1);
    chk("dw10_d", d, 12'd48);
    chk("dw10_w", w, 12'd1);
    chk("dw10_ds_wr_drain", ds_wr, 12'd7);
    chk("dw10_dgates_frz", dgates, 12'd55);
    en_dwu = 1'b0;
    step(5);
    chk("dwfrz_d", d, 12'd48);
    chk("dwfrz_w", w, 12'd1);
    chk("dwfrz_ds_wr", ds_wr, 12'd0);
    en_dwu = 1'b1;
    step(1);
    chk("dw11_d", d, 12'd49);
    chk("dw11_w", w, 12'd54);
    step(519);
    chk("dw530_d", d, 12'd40);
    chk("dw530_w", w, 12'd0);
    step(3180);
    chk("dw3710_d", d, 12'd48);
    chk("dw3710_w", w, 12'd0);

    // Delta freeze mid-slot and resume
    en_dwu = 1'b0; en_delta = 1'b1;
    step(5);
    chk("dlr5_aioht", aioht, 12'd40);
    en_delta = 1'b0;
    step(5);
    chk("dlfrz_aioht", aioht, 12'd40);
    chk("dlfrz_dgates", dgates, 12'd55);
    en_delta = 1'b1;
    step(6);
    chk("dlr11_aioht", aioht, 12'd40);
    step(1);
    chk("dlr12_aioht", aioht, 12'd41);
    chk("dlr12_dgates", dgates, 12'd40);
    chk("dlr12_ds_rd", ds_rd, 12'd1);
    step(563);
    chk("dl671_aioht", aioht, 12'd7);
    chk("dl671_dgates", dgates, 12'd6);
    step(1);
    chk("dl672_aioht", aioht, 12'd48);
    chk("dl672_dgates", dgates, 12'd7);

    // Mid-run reset with both enables high
    en_dwu = 1'b1;
    step(17);
    chk("pre_rst_ds_rd", ds_rd, 12'd1);
    rst = 1'b1;
    step(1);
    chk("mrst_aioht", aioht, 12'd48);
    chk("mrst_dgates", dgates, 12'd48);
    chk("mrst_ds_rd", ds_rd, 12'd0);
    chk("mrst_ds_wr", ds_wr, 12'd0);
    chk("mrst_d", d, 12'd48);
    chk("mrst_w", w, 12'd0);
    rst = 1'b0;
    step(6);
    chk("post_rst_ds_wr", ds_wr, 12'd0);
    chk("post_rst_aioht", aioht, 12'd48);
    chk("post_rst_d", d, 12'd54);
    chk("post_rst_w", w, 12'd318);

    // Wide-row instance: NUM_CELL=53, DWU_DELAY=3
    en_delta = 1'b0; en_dwu = 1'b0; en_dwu_b = 1'b1;
    step(1);
    chk("b1_d", b_d, 12'd319);
    chk("b1_w", b_w, 12'd53);
    step(51);
    chk("b52_d", b_d, 12'd370);
    chk("b52_w", b_w, 12'd2756);
    step(3);
    chk("b55_d_hold", b_d, 12'd370);
    chk("b55_w_hold", b_w, 12'd2756);
    step(1);
    chk("b56_d", b_d, 12'd318);
    chk("b56_w", b_w, 12'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
